// File: rtl/stream_mux_rr.sv
// Round-robin, packet-locked N:1 valid/ready stream mux with a single registered output stage.
// Optional feature macro MUX_FORCE_SEL_EN adds force_en/force_sel direct channel selection while idle.
module stream_mux_rr #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  output logic           out_last,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
`ifdef MUX_FORCE_SEL_EN
  ,
  input  logic           force_en,
  input  logic [SW-1:0]  force_sel
`endif
);

  localparam int SW1 = SW + 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SW-1:0] lock_ch_q, lock_ch_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [SW-1:0] out_sel_q, out_sel_d;

  logic [W-1:0]  ch_data [N];
  logic [N-1:0]  valid_rot;
  logic [SW:0]   rr_off;
  logic [SW:0]   rr_sum;
  logic [SW-1:0] rr_idx;
  logic          rr_found;
  logic [SW-1:0] gnt;
  logic          gnt_ok;
  logic [SW-1:0] next_ptr;
  logic          can_load;
  logic          xfer;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      assign ch_data[gi] = in_data[gi*W +: W];
    end
  endgenerate

  // Rotate so rr_ptr lands on bit 0; the lowest set bit is then the round-robin winner.
  assign valid_rot = N'({in_valid, in_valid} >> rr_ptr_q);

  always_comb begin
    rr_found = 1'b0;
    rr_off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        rr_found = 1'b1;
        rr_off   = SW1'(k);
      end
    end
  end

  // Offset back to an absolute channel, wrapping exactly at N (N need not be a power of two).
  assign rr_sum = {1'b0, rr_ptr_q} + rr_off;
  assign rr_idx = (rr_sum >= SW1'(N)) ? SW'(rr_sum - SW1'(N)) : SW'(rr_sum);

  assign can_load = !out_valid_q || out_ready;

  always_comb begin
    gnt    = rr_idx;
    gnt_ok = rr_found;
    if (state_q == LOCKED) begin
      // Locked channel keeps the grant even while it is not valid.
      gnt    = lock_ch_q;
      gnt_ok = 1'b1;
    end
`ifdef MUX_FORCE_SEL_EN
    else if (force_en) begin
      gnt    = force_sel;
      gnt_ok = ({1'b0, force_sel} < SW1'(N)) && in_valid[force_sel];
    end
`endif
  end

  assign xfer     = can_load && gnt_ok && in_valid[gnt];
  assign next_ptr = (gnt == SW'(N - 1)) ? '0 : gnt + 1'b1;

  always_comb begin
    in_ready = '0;
    if (can_load && gnt_ok) begin
      in_ready[gnt] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_ch_d   = lock_ch_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;

    if (xfer) begin
      out_data_d  = ch_data[gnt];
      out_last_d  = in_last[gnt];
      out_sel_d   = gnt;
      out_valid_d = 1'b1;
      case (state_q)
        IDLE: begin
          if (in_last[gnt]) begin
            rr_ptr_d = next_ptr;
          end else begin
            state_d   = LOCKED;
            lock_ch_d = gnt;
          end
        end
        LOCKED: begin
          if (in_last[gnt]) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      lock_ch_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_ch_q   <= lock_ch_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: a 4-channel and a 3-channel instance share one stimulus and are
// each compared every cycle against a packet-level reference model, plus directed sequences.
module tb_stream_mux_rr;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_valid;
  logic [3:0]     in_last;
  logic           out_ready;

  logic [3:0]     rdy4;
  logic [W-1:0]   od4;
  logic           ov4, ol4;
  logic [1:0]     os4;
  logic [2:0]     rdy3;
  logic [W-1:0]   od3;
  logic           ov3, ol3;
  logic [1:0]     os3;
`ifdef MUX_FORCE_SEL_EN
  logic           force_en;
  logic [1:0]     force_sel;
`endif

  always #5 clk = ~clk;

  stream_mux_rr #(.N(4), .W(W)) u4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (rdy4),
    .out_data  (od4),
    .out_valid (ov4),
    .out_last  (ol4),
    .out_sel   (os4),
    .out_ready (out_ready)
`ifdef MUX_FORCE_SEL_EN
    ,
    .force_en  (force_en),
    .force_sel (force_sel)
`endif
  );

  stream_mux_rr #(.N(3), .W(W)) u3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data[3*W-1:0]),
    .in_valid  (in_valid[2:0]),
    .in_last   (in_last[2:0]),
    .in_ready  (rdy3),
    .out_data  (od3),
    .out_valid (ov3),
    .out_last  (ol3),
    .out_sel   (os3),
    .out_ready (out_ready)
`ifdef MUX_FORCE_SEL_EN
    ,
    .force_en  (force_en),
    .force_sel (force_sel)
`endif
  );

  // Reference model, index 0 = 4-channel instance, index 1 = 3-channel instance.
  int         m_ptr    [2];
  int         m_lock   [2];
  bit         m_locked [2];
  bit         m_ov     [2];
  bit         m_ol     [2];
  int         m_os     [2];
  logic [7:0] m_od     [2];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       ordy;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] sel;
  } vec_t;

  vec_t tbl [12];

  function automatic int nch(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  task automatic model_reset(input int i);
    m_ptr[i] = 0; m_lock[i] = 0; m_locked[i] = 0;
    m_ov[i] = 0; m_ol[i] = 0; m_os[i] = 0; m_od[i] = 8'h00;
  endtask

  // Channel that currently holds the grant, or -1 when none.
  function automatic int model_grant(input int i);
    int n;
    n = nch(i);
    if (m_locked[i]) return m_lock[i];
`ifdef MUX_FORCE_SEL_EN
    if (force_en) return (int'(force_sel) < n && in_valid[force_sel]) ? int'(force_sel) : -1;
`endif
    for (int k = 0; k < n; k++) begin
      if (in_valid[(m_ptr[i] + k) % n]) return (m_ptr[i] + k) % n;
    end
    return -1;
  endfunction

  function automatic int exp_ready(input int i);
    int g;
    g = model_grant(i);
    if ((!m_ov[i] || out_ready) && g >= 0) return 1 << g;
    return 0;
  endfunction

  task automatic model_step(input int i, output bit x);
    int g;
    g = model_grant(i);
    x = 0;
    if ((!m_ov[i] || out_ready) && g >= 0 && in_valid[g]) begin
      x = 1;
      m_od[i] = in_data[g*W +: W];
      m_ol[i] = in_last[g];
      m_os[i] = g;
      m_ov[i] = 1;
      if (in_last[g]) begin
        m_locked[i] = 0;
        m_ptr[i]    = (g + 1) % nch(i);
      end else begin
        m_locked[i] = 1;
        m_lock[i]   = g;
      end
    end else if (out_ready) begin
      m_ov[i] = 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " u4 out_valid"}, int'(ov4), int'(m_ov[0]));
    chk({tag, " u4 out_data"},  int'(od4), int'(m_od[0]));
    chk({tag, " u4 out_last"},  int'(ol4), int'(m_ol[0]));
    chk({tag, " u4 out_sel"},   int'(os4), m_os[0]);
    chk({tag, " u3 out_valid"}, int'(ov3), int'(m_ov[1]));
    chk({tag, " u3 out_data"},  int'(od3), int'(m_od[1]));
    chk({tag, " u3 out_last"},  int'(ol3), int'(m_ol[1]));
    chk({tag, " u3 out_sel"},   int'(os3), m_os[1]);
  endtask

  // Called with inputs already set while clk is low; returns at the following falling edge.
  task automatic cycle(input string tag);
    bit x0, x1;
    #1;
    chk({tag, " u4 in_ready"}, int'(rdy4), exp_ready(0));
    chk({tag, " u3 in_ready"}, int'(rdy3), exp_ready(1));
    @(posedge clk);
    x0 = 0; x1 = 0;
    if (!rst_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, x0);
      model_step(1, x1);
    end
    #1;
    check_outputs(tag);
    $display("%s: t=%0t u4 %s ch%0d data %02h last %0d | u3 %s ch%0d data %02h last %0d",
             tag, $time, x0 ? "beat" : "----", m_os[0], m_od[0], m_ol[0],
             x1 ? "beat" : "----", m_os[1], m_od[1], m_ol[1]);
    @(negedge clk);
  endtask

  task automatic set_in(input logic [3:0] v, input logic [3:0] l, input logic ordy);
    in_valid  = v;
    in_last   = l;
    out_ready = ordy;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            v      l      ordy  rdy      ov    sel
    tbl[0]  = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[1]  = '{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[2]  = '{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[3]  = '{4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[4]  = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[5]  = '{4'h7, 4'h5, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[6]  = '{4'h7, 4'h5, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[7]  = '{4'h5, 4'h5, 1'b1, 4'b0010, 1'b0, 2'd1};
    tbl[8]  = '{4'h7, 4'h7, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[9]  = '{4'h5, 4'h5, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[10] = '{4'h0, 4'h5, 1'b1, 4'b0000, 1'b0, 2'd2};
    tbl[11] = '{4'h0, 4'h5, 1'b0, 4'b0000, 1'b0, 2'd2};

    rst_n = 1'b0;
    in_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    set_in(4'h0, 4'h0, 1'b1);
`ifdef MUX_FORCE_SEL_EN
    force_en = 1'b0;
    force_sel = 2'd0;
`endif
    model_reset(0);
    model_reset(1);
    repeat (2) @(negedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin fairness, packet lock with bubble, drain.
    for (int t = 0; t < 12; t++) begin
      set_in(tbl[t].v, tbl[t].l, tbl[t].ordy);
      #1;
      chk($sformatf("tbl%0d in_ready", t), int'(rdy4), int'(tbl[t].rdy));
      cycle($sformatf("tbl%0d", t));
      chk($sformatf("tbl%0d out_valid", t), int'(ov4), int'(tbl[t].ov));
      chk($sformatf("tbl%0d out_sel", t), int'(os4), int'(tbl[t].sel));
    end

    // Backpressure: A5 from ch3 held for 5 stalled cycles while inputs change.
    in_data = {8'hA5, 8'hC2, 8'hC1, 8'hC0};
    set_in(4'h8, 4'hF, 1'b1);
    cycle("bp load");
    chk("bp load data", int'(od4), 8'hA5);
    in_data = {8'h5A, 8'hC2, 8'hC1, 8'hC0};
    for (int t = 0; t < 5; t++) begin
      set_in(4'hF, 4'hF, 1'b0);
      #1;
      chk("bp in_ready", int'(rdy4), 0);
      cycle("bp hold");
      chk("bp hold data", int'(od4), 8'hA5);
      chk("bp hold valid", int'(ov4), 1);
      chk("bp hold sel", int'(os4), 3);
    end
    set_in(4'hF, 4'hF, 1'b1);
    #1;
    chk("bp release in_ready", int'(rdy4), 1);
    cycle("bp release");
    chk("bp release sel", int'(os4), 0);
    chk("bp release data", int'(od4), 8'hC0);

    // Reset in the middle of a packet locked on ch1.
    set_in(4'hF, 4'h0, 1'b1);
    cycle("pkt start");
    chk("pkt start sel", int'(os4), 1);
    rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    chk("async rst out_valid", int'(ov4), 0);
    chk("async rst out_sel", int'(os4), 0);
    chk("async rst out_data", int'(od4), 0);
    @(negedge clk);
    cycle("in reset");
    rst_n = 1'b1;
    set_in(4'hF, 4'hF, 1'b1);
    #1;
    chk("post rst in_ready", int'(rdy4), 1);
    cycle("post rst");
    chk("post rst sel", int'(os4), 0);

    // Exact wrap on the 3-channel instance.
    set_in(4'h4, 4'hF, 1'b1);
    cycle("wrap ch2");
    chk("wrap ch2 sel", int'(os3), 2);
    set_in(4'h7, 4'hF, 1'b1);
    cycle("wrap ch0");
    chk("wrap ch0 sel", int'(os3), 0);
    cycle("wrap ch1");
    chk("wrap ch1 sel", int'(os3), 1);
    set_in(4'h2, 4'hF, 1'b1);
    cycle("lone ch1");
    chk("lone ch1 sel", int'(os3), 1);

`ifdef MUX_FORCE_SEL_EN
    force_en = 1'b1;
    force_sel = 2'd3;
    for (int t = 0; t < 3; t++) begin
      set_in(4'hF, 4'hF, 1'b1);
      #1;
      chk("force3 u3 in_ready", int'(rdy3), 0);
      cycle("force3");
      chk("force3 sel", int'(os4), 3);
    end
    force_en = 1'b0;
    set_in(4'h1, 4'h0, 1'b1);
    cycle("force pkt start");
    chk("force pkt start sel", int'(os4), 0);
    force_en = 1'b1;
    set_in(4'hF, 4'h0, 1'b1);
    #1;
    chk("force mid pkt in_ready", int'(rdy4), 1);
    cycle("force mid pkt");
    chk("force mid pkt sel", int'(os4), 0);
    set_in(4'hF, 4'h1, 1'b1);
    cycle("force pkt end");
    chk("force pkt end sel", int'(os4), 0);
    set_in(4'hF, 4'hF, 1'b1);
    cycle("force after pkt");
    chk("force after pkt sel", int'(os4), 3);
    force_en = 1'b0;
`endif

    // Randomised traffic against the model, with occasional resets.
    for (int t = 0; t < 400; t++) begin
      in_data   = $urandom;
      in_valid  = 4'($urandom);
      for (int c = 0; c < 4; c++) in_last[c] = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_FORCE_SEL_EN
      force_en  = ($urandom_range(0, 7) == 0);
      force_sel = 2'($urandom);
`endif
      if ($urandom_range(0, 96) == 0) begin
        rst_n = 1'b0;
        #0;
        model_reset(0);
        model_reset(1);
      end else begin
        rst_n = 1'b1;
      end
      cycle($sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised successor of the team's fixed 4:1 single-bit mux.
- Selects one of N channels, each W bits wide with valid/ready/last, onto one registered output stream.
- Arbitration is round-robin and packet-locked.
- Sits between multiple producers (register-file read ports, ALU result sources) and a single consumer bus.

Parameters:
- N, 4, number of input channels (1..16; need not be a power of two).
- W, 8, data width per channel.
- SW (localparam), max(1, clog2(N)), width of the channel index.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel beat valid.
- in_last  input  N  per-channel end-of-packet marker, qualified by in_valid.
- in_ready  output  N  per-channel accept; combinational.
- out_data  output  W  registered selected data.
- out_valid  output  1  registered output valid.
- out_last  output  1  registered copy of the accepted beat's in_last.
- out_sel  output  SW  registered index of the channel that supplied out_data.
- out_ready  input  1  consumer accept.

Behaviour:
- Reset (async assert, sync-safe deassert): out_valid=0, out_data=0, out_last=0, out_sel=0, rr_ptr=0, state=IDLE, lock_ch=0.
- Stage free: can_load = !out_valid || out_ready.
- Handshake rule: a beat transfers when in_valid[i] && in_ready[i].
  - At most one in_ready bit is high per cycle.
  - in_ready is 0 everywhere when can_load=0.
- State IDLE:
  - Grant goes to the first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N.
  - in_ready[g] = can_load.
  - On transfer with in_last[g]=0: go to LOCKED, lock_ch=g.
  - On transfer with in_last[g]=1: stay IDLE, rr_ptr = (g+1) mod N.
- State LOCKED:
  - Only lock_ch is eligible; in_ready[lock_ch] = can_load, all other bits 0, even if lock_ch is not valid (bubble allowed).
  - On transfer with in_last=1: go to IDLE, rr_ptr = (lock_ch+1) mod N.
- Output load: on any transfer, out_data, out_last and out_sel load from the granted channel and out_valid becomes 1.
- Output drain: if out_ready=1 and out_valid=1 with no new transfer, out_valid becomes 0. Data regs hold their values.
- Simultaneous drain and load: both happen in the same cycle, giving full throughput of 1 beat/clk.
- Backpressure: out_ready=0 with out_valid=1 holds all out_* stable and forces in_ready=0.
- Latency: exactly 1 clk from input transfer to out_valid.
- rr_ptr advances only on a last-beat transfer, never on idle cycles. Wrap from N-1 to 0 must be exact for non-power-of-two N.
- N=1: arbitration degenerates to a pass-through register; out_sel=0 always.
- Reset mid-packet: lock is dropped, the buffered beat is discarded, and the first post-reset grant starts from channel 0.
- No in_valid asserted in IDLE: no grant, state and rr_ptr unchanged.

Optional Feature:
- Macro: MUX_FORCE_SEL_EN.
- When defined, adds input ports force_en (1) and force_sel (SW), giving direct select-line control as in the original mux.
- While force_en=1 in IDLE, the grant is force_sel regardless of rr_ptr.
  - If in_valid[force_sel]=0, no grant is made.
  - force_sel >= N grants nothing.
  - Locking and rr_ptr update on last beats behave as normal.
- force_en is ignored in LOCKED, so a packet is never split.
- When not defined: ports are absent and arbitration is pure round-robin.

Test Plan:
- Reset: rst_n=0 mid-stream with out_valid=1 -> same-cycle out_valid=0, out_sel=0. First grant after release goes to ch0 when all 4 channels are valid.
- Round-robin fairness: N=4, all in_valid=1, all in_last=1, out_ready=1 -> out_sel sequence 0,1,2,3,0,... with one beat per clk.
- Packet lock: ch1 sends 3 beats with in_last on beat 3 while ch0 and ch2 are valid -> out_sel=1,1,1 then 2. ch0/ch2 in_ready stay 0 during the packet, including a bubble cycle where ch1 in_valid=0.
- Backpressure: out_ready=0 for 5 clks with out_data=8'hA5 held -> out_data, out_valid, out_sel stable and in_ready=0. When out_ready=1, the next beat loads in the same cycle.
- Wrap with N=3: grants on ch2 with last -> next grant is ch0. A lone valid ch1 is granted regardless of rr_ptr.
- MUX_FORCE_SEL_EN: force_en=1, force_sel=3, all valid -> grants ch3 repeatedly. force_sel asserted mid-packet on ch0 -> ch0 completes its packet first.
